// File: rtl/uart_cmd_wrapper_if.sv
// Byte-level handshake bundle between the UART transceiver, this command-assembly
// stage and the command processor.
interface uart_cmd_wrapper_if;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CMD_W  = 24;

    logic              rx_rdy;
    logic [BYTE_W-1:0] rx_data;
    logic              clr_rx_rdy;
    logic [CMD_W-1:0]  cmd;
    logic              cmd_rdy;
    logic              clr_cmd_rdy;
    logic              frame_err;
    logic [BYTE_W-1:0] resp;
    logic              send_resp;
    logic              tx_start;
    logic [BYTE_W-1:0] tx_data;
    logic              tx_done;
    logic              resp_sent;

    // Environment side: UART transceiver plus command processor
    modport master (
        output rx_rdy, rx_data, clr_cmd_rdy, resp, send_resp, tx_done,
        input  clr_rx_rdy, cmd, cmd_rdy, frame_err, tx_start, tx_data, resp_sent
    );

    modport slave (
        input  rx_rdy, rx_data, clr_cmd_rdy, resp, send_resp, tx_done,
        output clr_rx_rdy, cmd, cmd_rdy, frame_err, tx_start, tx_data, resp_sent
    );
endinterface

// File: rtl/uart_cmd_wrapper.sv
// Assembles three UART bytes (MSB first) into a 24-bit command with an inter-byte
// timeout, and hands single response bytes back to the UART transmitter.
module uart_cmd_wrapper #(
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    uart_cmd_wrapper_if.slave   bus
);
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CMD_W  = 24;
    localparam int unsigned TMR_W  = 24;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {B0, B1, B2, HOLD} rx_state_t;
    typedef enum logic       {TX_IDLE, TX_BUSY} tx_state_t;

    rx_state_t         rx_state, rx_state_n;
    logic [TMR_W-1:0]  timer, timer_n;
    logic [CMD_W-1:0]  cmd, cmd_n;
    logic              cmd_rdy, cmd_rdy_n;
    logic              clr_rx_rdy, clr_rx_rdy_n;
    logic              frame_err, frame_err_n;
    logic              accept;

    tx_state_t         tx_state, tx_state_n;
    logic [BYTE_W-1:0] tx_data, tx_data_n;
    logic              tx_start, tx_start_n;
    logic              resp_sent, resp_sent_n;

    // A byte still flagged while clr_rx_rdy is high has already been taken
    assign accept = bus.rx_rdy && !clr_rx_rdy && (rx_state != HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state   <= B0;
            timer      <= '0;
            cmd        <= '0;
            cmd_rdy    <= 1'b0;
            clr_rx_rdy <= 1'b0;
            frame_err  <= 1'b0;
            tx_state   <= TX_IDLE;
            tx_data    <= '0;
            tx_start   <= 1'b0;
            resp_sent  <= 1'b0;
        end else begin
            rx_state   <= rx_state_n;
            timer      <= timer_n;
            cmd        <= cmd_n;
            cmd_rdy    <= cmd_rdy_n;
            clr_rx_rdy <= clr_rx_rdy_n;
            frame_err  <= frame_err_n;
            tx_state   <= tx_state_n;
            tx_data    <= tx_data_n;
            tx_start   <= tx_start_n;
            resp_sent  <= resp_sent_n;
        end
    end

    // RX assembly; an accept on the expiry cycle takes priority over the timeout
    always_comb begin
        rx_state_n   = rx_state;
        timer_n      = timer;
        cmd_n        = cmd;
        cmd_rdy_n    = cmd_rdy;
        clr_rx_rdy_n = 1'b0;
        frame_err_n  = 1'b0;
        case (rx_state)
            B0: begin
                timer_n = '0;
                if (accept) begin
                    cmd_n[23:16] = bus.rx_data;
                    clr_rx_rdy_n = 1'b1;
                    rx_state_n   = B1;
                end
            end
            B1, B2: begin
                if (accept) begin
                    clr_rx_rdy_n = 1'b1;
                    timer_n      = '0;
                    if (rx_state == B1) begin
                        cmd_n[15:8] = bus.rx_data;
                        rx_state_n  = B2;
                    end else begin
                        cmd_n[7:0]  = bus.rx_data;
                        cmd_rdy_n   = 1'b1;
                        rx_state_n  = HOLD;
                    end
                end else if (timer == TMR_LAST) begin
                    timer_n     = '0;
                    frame_err_n = 1'b1;
                    rx_state_n  = B0;
                end else begin
                    timer_n = timer + TMR_W'(1);
                end
            end
            HOLD: begin
                timer_n = '0;
                if (bus.clr_cmd_rdy) begin
                    cmd_rdy_n  = 1'b0;
                    rx_state_n = B0;
                end
            end
            default: rx_state_n = B0;
        endcase
    end

    // TX handoff; requests arriving while busy are dropped
    always_comb begin
        tx_state_n  = tx_state;
        tx_data_n   = tx_data;
        tx_start_n  = 1'b0;
        resp_sent_n = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (bus.send_resp) begin
                    tx_data_n  = bus.resp;
                    tx_start_n = 1'b1;
                    tx_state_n = TX_BUSY;
                end
            end
            TX_BUSY: begin
                if (bus.tx_done) begin
                    resp_sent_n = 1'b1;
                    tx_state_n  = TX_IDLE;
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    assign bus.cmd        = cmd;
    assign bus.cmd_rdy    = cmd_rdy;
    assign bus.clr_rx_rdy = clr_rx_rdy;
    assign bus.frame_err  = frame_err;
    assign bus.tx_data    = tx_data;
    assign bus.tx_start   = tx_start;
    assign bus.resp_sent  = resp_sent;
endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Scoreboard bench for uart_cmd_wrapper: drivers push expected commands, frame errors
// and TX bytes; an independent negedge monitor pops and compares.
module tb_uart_cmd_wrapper;
    localparam int unsigned TO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_cmd_wrapper_if bus();

    uart_cmd_wrapper #(.TIMEOUT_CYC(TO)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [23:0] cmd_q[$];
    logic [7:0]  tx_q[$];
    int          ferr_pending = 0;
    int          sent_pending = 0;
    int          clr_seen = 0;
    int          bytes_sent = 0;

    // Reference model of the command being assembled
    logic [7:0]  part[3];
    int          nbytes = 0;
    int          last_hold = 0;

    logic [23:0] held_cmd = '0;
    logic [7:0]  tx_cur = '0;
    logic        tx_chk = 1'b0;
    logic        prev_cmd_rdy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_clr_rx_rdy"}, 32'(bus.clr_rx_rdy), 32'd0);
        check({tag, "_cmd"},        32'(bus.cmd),        32'd0);
        check({tag, "_cmd_rdy"},    32'(bus.cmd_rdy),    32'd0);
        check({tag, "_frame_err"},  32'(bus.frame_err),  32'd0);
        check({tag, "_tx_start"},   32'(bus.tx_start),   32'd0);
        check({tag, "_tx_data"},    32'(bus.tx_data),    32'd0);
        check({tag, "_resp_sent"},  32'(bus.resp_sent),  32'd0);
    endtask

    // Monitor: every DUT-presented event is matched against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.cmd_rdy && !prev_cmd_rdy) begin
                    check("cmd_rdy_expected", 32'(cmd_q.size() > 0), 32'd1);
                    if (cmd_q.size() > 0) begin
                        held_cmd = cmd_q.pop_front();
                        check("cmd_value", 32'(bus.cmd), 32'(held_cmd));
                    end
                end else if (bus.cmd_rdy) begin
                    check("cmd_hold_stable", 32'(bus.cmd), 32'(held_cmd));
                end
                if (bus.clr_rx_rdy) begin
                    clr_seen++;
                    check("no_accept_while_cmd_rdy", 32'(prev_cmd_rdy), 32'd0);
                end
                if (bus.frame_err) begin
                    check("frame_err_expected", 32'(ferr_pending > 0), 32'd1);
                    if (ferr_pending > 0) ferr_pending--;
                end
                if (bus.tx_start) begin
                    check("tx_start_expected", 32'(tx_q.size() > 0), 32'd1);
                    if (tx_q.size() > 0) check("tx_data_start", 32'(bus.tx_data), 32'(tx_q.pop_front()));
                end
                if (tx_chk) check("tx_data_stable", 32'(bus.tx_data), 32'(tx_cur));
                if (bus.resp_sent) begin
                    check("resp_sent_expected", 32'(sent_pending > 0), 32'd1);
                    if (sent_pending > 0) sent_pending--;
                end
            end
            prev_cmd_rdy = bus.cmd_rdy & rst_n;
        end
    end

    // Command processor: takes each command after a random delay
    initial begin
        int d;
        bus.clr_cmd_rdy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.cmd_rdy) begin
                d = int'($urandom_range(0, 4));
                repeat (d) @(posedge clk);
                #1 bus.clr_cmd_rdy = 1'b1;
                @(posedge clk);
                #1 bus.clr_cmd_rdy = 1'b0;
                @(negedge clk);
                check("cmd_rdy_fall", 32'(bus.cmd_rdy), 32'd0);
            end
        end
    end

    // One UART byte: idle `gap` cycles, present it until consumed, keep rx_rdy `hold` extra cycles
    task automatic rx_byte(input logic [7:0] b, input int gap, input int hold);
        logic got;
        // A partial command dies when the next accept comes 17+ cycles after the last one
        if (nbytes > 0 && gap + last_hold >= int'(TO)) begin
            ferr_pending++;
            nbytes = 0;
        end
        part[nbytes] = b;
        nbytes++;
        if (nbytes == 3) begin
            cmd_q.push_back({part[0], part[1], part[2]});
            nbytes = 0;
        end
        repeat (gap) @(posedge clk);
        #1;
        bus.rx_data = b;
        bus.rx_rdy  = 1'b1;
        bytes_sent++;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(posedge clk);
            #1;
            if (bus.clr_rx_rdy) got = 1'b1;
        end
        check("rx_byte_consumed", 32'(got), 32'd1);
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1;
        end
        bus.rx_rdy  = 1'b0;
        bus.rx_data = 8'($urandom);
        last_hold   = hold;
    endtask

    // One response byte; optional extra send_resp pulses while busy must be dropped
    task automatic tx_txn(input logic [7:0] r, input int d, input logic drops, input logic first_drop);
        bus.resp      = r;
        bus.send_resp = 1'b1;
        tx_q.push_back(r);
        @(posedge clk);
        #1;
        bus.send_resp = 1'b0;
        bus.resp      = 8'($urandom);
        tx_cur        = r;
        tx_chk        = 1'b1;
        for (int i = 0; i < d; i++) begin
            bus.send_resp = drops && ((first_drop && i == 0) || $urandom_range(0, 2) == 0);
            bus.resp      = (first_drop && i == 0) ? 8'h5A : 8'($urandom);
            @(posedge clk);
            #1;
        end
        bus.send_resp = 1'b0;
        bus.tx_done   = 1'b1;
        sent_pending++;
        @(posedge clk);
        #1;
        bus.tx_done = 1'b0;
        @(posedge clk);
        #1;
        tx_chk = 1'b0;
        if ($urandom_range(0, 3) == 0) begin
            bus.tx_done = 1'b1;
            @(posedge clk);
            #1;
            bus.tx_done = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (cmd_q.size() == 0 && tx_q.size() == 0 && ferr_pending == 0 && sent_pending == 0) break;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        int hold;
        bus.rx_rdy    = 1'b0;
        bus.rx_data   = '0;
        bus.resp      = '0;
        bus.send_resp = 1'b0;
        bus.tx_done   = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic command, then a byte that must wait for the command to be taken
        rx_byte(8'h02, 1, 0);
        rx_byte(8'h01, 2, 0);
        rx_byte(8'h00, 1, 0);
        rx_byte(8'h05, 1, 0);
        rx_byte(8'h06, 3, 0);
        rx_byte(8'h07, 15, 0);

        // Timeout discards the partial command; the late byte starts a new one
        rx_byte(8'hAA, 4, 0);
        rx_byte(8'h03, 16, 0);
        rx_byte(8'h12, 2, 0);
        rx_byte(8'h34, 2, 0);

        // rx_rdy lingering after consumption; lingering counts toward the gap
        rx_byte(8'h44, 3, 1);
        rx_byte(8'h55, 2, 0);
        rx_byte(8'h66, 14, 0);
        rx_byte(8'h77, 2, 1);
        rx_byte(8'h88, 15, 0);
        rx_byte(8'h99, 1, 0);
        rx_byte(8'hAB, 1, 0);

        tx_txn(8'hA5, 3, 1'b1, 1'b1);
        drain();

        // Randomised concurrent RX and TX traffic
        fork
            begin
                for (int n = 0; n < 45; n++) begin
                    gap  = ($urandom_range(0, 9) < 2) ? int'($urandom_range(16, 24))
                                                       : int'($urandom_range(1, 15));
                    hold = ($urandom_range(0, 3) == 0) ? 1 : 0;
                    rx_byte(8'($urandom), gap, hold);
                end
            end
            begin
                for (int n = 0; n < 20; n++) begin
                    tx_txn(8'($urandom), int'($urandom_range(0, 6)), 1'b1, 1'b0);
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                end
            end
        join
        if (nbytes > 0) begin
            ferr_pending++;
            nbytes = 0;
        end
        repeat (24) @(posedge clk);
        #1;
        drain();
        repeat (10) @(posedge clk);
        #1;

        // Reset mid-command and mid-transmit
        last_hold = 0;
        rx_byte(8'h11, 1, 0);
        rx_byte(8'h22, 1, 0);
        bus.resp      = 8'h77;
        bus.send_resp = 1'b1;
        tx_q.push_back(8'h77);
        @(posedge clk);
        #1;
        bus.send_resp = 1'b0;
        tx_cur        = 8'h77;
        tx_chk        = 1'b1;
        @(posedge clk);
        #1;
        rst_n  = 1'b0;
        tx_chk = 1'b0;
        nbytes = 0;
        #1;
        check_idle("midreset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.tx_done = 1'b1;
        @(posedge clk);
        #1;
        bus.tx_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("post_reset_resp_sent", 32'(bus.resp_sent), 32'd0);
        check("post_reset_cmd_rdy", 32'(bus.cmd_rdy), 32'd0);
        rx_byte(8'hC1, 1, 0);
        rx_byte(8'hC2, 1, 0);
        rx_byte(8'hC3, 1, 0);
        drain();
        repeat (10) @(posedge clk);
        #1;

        check("cmd_queue_empty", 32'(cmd_q.size()), 32'd0);
        check("tx_queue_empty", 32'(tx_q.size()), 32'd0);
        check("frame_err_outstanding", 32'(ferr_pending), 32'd0);
        check("resp_sent_outstanding", 32'(sent_pending), 32'd0);
        check("clr_rx_rdy_count", 32'(clr_seen), 32'(bytes_sent));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
